// File: rtl/scarv_axi_slave_adapter_if.sv
// AXI4-lite address/data/response channels between the CPU-side master
// adapter and the slave adapter. No resp fields: every transaction is OKAY.
interface scarv_axi_slave_adapter_if;
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  modport master (
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    output mem_axi_rready,
    input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
    input  mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
  );

  modport slave (
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    input  mem_axi_rready,
    output mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
    output mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
  );
endinterface

// File: rtl/scarv_axi_slave_adapter.sv
// AXI4-lite responder that turns each transaction into one request on a native
// valid/ready memory port; one transaction in flight, round-robin read/write.
module scarv_axi_slave_adapter #(
  parameter bit ALIGN_ADDR = 1'b1
) (
  input  logic                           clk,
  input  logic                           resetn,
  scarv_axi_slave_adapter_if.slave       axi,
  output logic                           ram_valid,
  input  logic                           ram_ready,
  output logic                           ram_instr,
  output logic [31:0]                    ram_addr,
  output logic [31:0]                    ram_wdata,
  output logic [3:0]                     ram_wstrb,
  input  logic [31:0]                    ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WCOLLECT,
    S_MREQ,
    S_BRESP,
    S_RRESP
  } state_e;

  state_e      state_q, state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic        last_rd_q, last_rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;
  logic [31:0] rdata_q, rdata_d;

  logic        awready, wready, arready;
  logic        pick_wr, aw_hs, w_hs;

  logic unused_prot;
  assign unused_prot = ^{axi.mem_axi_awprot, axi.mem_axi_arprot[1:0]};

  function automatic logic [31:0] align_addr(input logic [31:0] a);
    return ALIGN_ADDR ? {a[31:2], 2'b00} : a;
  endfunction

  always_comb begin
    state_d   = state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    last_rd_d = last_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    instr_d   = instr_q;
    rdata_d   = rdata_q;
    awready   = 1'b0;
    wready    = 1'b0;
    arready   = 1'b0;
    pick_wr   = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Writes win only if a read is not waiting or the last grant was a read.
        pick_wr = (axi.mem_axi_awvalid || axi.mem_axi_wvalid) &&
                  (!axi.mem_axi_arvalid || last_rd_q);
        awready = pick_wr;
        wready  = pick_wr;
        arready = axi.mem_axi_arvalid && !pick_wr;
        if (axi.mem_axi_arvalid && !pick_wr) begin
          addr_d  = align_addr(axi.mem_axi_araddr);
          instr_d = axi.mem_axi_arprot[2];
          wstrb_d = '0;
          state_d = S_MREQ;
        end else if (pick_wr) begin
          aw_hs = axi.mem_axi_awvalid;
          w_hs  = axi.mem_axi_wvalid;
        end
      end
      S_WCOLLECT: begin
        awready = !aw_got_q;
        wready  = !w_got_q;
        aw_hs   = axi.mem_axi_awvalid && !aw_got_q;
        w_hs    = axi.mem_axi_wvalid && !w_got_q;
      end
      S_MREQ: begin
        // Reads are the only MREQ requests with no strobes set.
        if (ram_ready) begin
          if (wstrb_q != '0) begin
            state_d = S_BRESP;
          end else begin
            rdata_d = ram_rdata;
            state_d = S_RRESP;
          end
        end
      end
      S_BRESP: begin
        if (axi.mem_axi_bready) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          last_rd_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_RRESP: begin
        if (axi.mem_axi_rready) begin
          last_rd_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Write-half capture is shared by IDLE and WCOLLECT; the exit decision
    // needs the merged flags and strobes of both halves.
    if (aw_hs) begin
      addr_d   = align_addr(axi.mem_axi_awaddr);
      aw_got_d = 1'b1;
    end
    if (w_hs) begin
      wdata_d = axi.mem_axi_wdata;
      wstrb_d = axi.mem_axi_wstrb;
      w_got_d = 1'b1;
    end
    if (aw_hs || w_hs) begin
      instr_d = 1'b0;
      if (aw_got_d && w_got_d) begin
        state_d = (wstrb_d == '0) ? S_BRESP : S_MREQ;
      end else begin
        state_d = S_WCOLLECT;
      end
    end

    if (!resetn) begin
      awready = 1'b0;
      wready  = 1'b0;
      arready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      last_rd_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      instr_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      last_rd_q <= last_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign axi.mem_axi_awready = awready;
  assign axi.mem_axi_wready  = wready;
  assign axi.mem_axi_arready = arready;
  assign axi.mem_axi_bvalid  = (state_q == S_BRESP);
  assign axi.mem_axi_rvalid  = (state_q == S_RRESP);
  assign axi.mem_axi_rdata   = rdata_q;

  assign ram_valid = (state_q == S_MREQ);
  assign ram_instr = instr_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_wstrb = wstrb_q;

endmodule
